mem_ctrl: RTL and testbench

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_ctrl.sv | 93 +++++++++
 tb/tb_mem_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// Single-port memory controller with a programmable wait-state FSM.
// Captures one access per request and acknowledges it with a one-cycle pulse.
module mem_ctrl #(
  parameter int unsigned WAIT_STATES = 2,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DATA_W      = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              req,
  input  logic              we,
  output logic [DATA_W-1:0] rdata,
  output logic              ack,
  output logic              busy
);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StWait   = 2'd1,
    StAccess = 2'd2,
    StAck    = 2'd3
  } state_e;

  localparam logic [3:0] WaitLoad = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_e            state_q;
  logic [3:0]        cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              we_q;

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Storage has no reset so its contents survive a controller reset.
  always_ff @(posedge clk) begin
    if (state_q == StAccess && we_q) begin
      mem[addr_q] <= wdata_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      rdata   <= '0;
      ack     <= 1'b0;
      busy    <= 1'b0;
    end else begin
      ack <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req) begin
            addr_q  <= addr;
            wdata_q <= wdata;
            we_q    <= we;
            busy    <= 1'b1;
            if (WAIT_STATES > 0) begin
              state_q <= StWait;
              cnt_q   <= WaitLoad;
            end else begin
              state_q <= StAccess;
            end
          end
        end
        StWait: begin
          if (cnt_q == 4'd0) begin
            state_q <= StAccess;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StAccess: begin
          if (!we_q) begin
            rdata <= mem[addr_q];
          end
          ack     <= 1'b1;
          state_q <= StAck;
        end
        StAck: begin
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: two instances (2 and 0 wait states) driven
// from shared stimulus and compared against a behavioural memory model.
module tb_mem_ctrl;

  logic       clk;
  logic       reset;
  logic [7:0] addr;
  logic [7:0] wdata;
  logic       req;
  logic       we;
  logic       use0;

  logic       req2, req0;
  logic [7:0] rdata2, rdata0;
  logic       ack2, ack0, busy2, busy0;
  logic [7:0] rdata_m;
  logic       ack_m, busy_m;

  int checks;
  int errors;

  logic [7:0] ref_mem [2][256];
  logic [7:0] last_rd [2];

  assign req2    = req && !use0;
  assign req0    = req && use0;
  assign rdata_m = use0 ? rdata0 : rdata2;
  assign ack_m   = use0 ? ack0 : ack2;
  assign busy_m  = use0 ? busy0 : busy2;

  mem_ctrl #(.WAIT_STATES(2), .ADDR_W(8), .DATA_W(8)) dut2 (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .wdata (wdata),
    .req   (req2),
    .we    (we),
    .rdata (rdata2),
    .ack   (ack2),
    .busy  (busy2)
  );

  mem_ctrl #(.WAIT_STATES(0), .ADDR_W(8), .DATA_W(8)) dut0 (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .wdata (wdata),
    .req   (req0),
    .we    (we),
    .rdata (rdata0),
    .ack   (ack0),
    .busy  (busy0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One complete access on the instance selected by use0; called just after a rising edge.
  task automatic do_access(input logic w, input logic [7:0] a, input logic [7:0] d,
                           input bit toggle);
    int s;
    int ws;
    int n;
    s  = use0 ? 1 : 0;
    ws = use0 ? 0 : 2;
    check_eq("busy_idle", 32'(busy_m), 32'd0);
    we = w; addr = a; wdata = d; req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    check_eq("busy_start", 32'(busy_m), 32'd1);
    n = 0;
    while (!ack_m && n < 20) begin
      if (toggle) begin
        addr  = 8'($urandom);
        wdata = 8'($urandom);
        we    = 1'($urandom);
      end
      @(posedge clk); #1;
      n++;
    end
    check_eq("ack_latency", 32'(n), 32'(ws + 1));
    if (w) begin
      ref_mem[s][a] = d;
      check_eq("rdata_hold", 32'(rdata_m), 32'(last_rd[s]));
    end else begin
      last_rd[s] = ref_mem[s][a];
      check_eq("read_data", 32'(rdata_m), 32'(ref_mem[s][a]));
    end
    @(posedge clk); #1;
    check_eq("ack_single", 32'(ack_m), 32'd0);
    check_eq("busy_end", 32'(busy_m), 32'd0);
  endtask

  initial begin
    int k;
    int prev;
    logic [7:0] cur_a, cur_d;

    checks = 0;
    errors = 0;
    reset = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; use0 = 1'b0;
    last_rd[0] = '0;
    last_rd[1] = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy", 32'(busy2), 32'd0);
    check_eq("rst_ack", 32'(ack2), 32'd0);
    check_eq("rst_rdata", 32'(rdata2), 32'd0);
    reset = 1'b1;

    // Basic write / read-back / hold on the 2-wait-state instance.
    do_access(1'b1, 8'h10, 8'hA5, 1'b0);
    do_access(1'b0, 8'h10, 8'h00, 1'b0);
    do_access(1'b1, 8'h11, 8'h3C, 1'b0);
    check_eq("rdata_after_wr", 32'(rdata2), 32'h00A5);

    // Inputs toggled mid-access must not disturb it or neighbouring words.
    do_access(1'b1, 8'h1F, 8'h1F, 1'b0);
    do_access(1'b1, 8'h21, 8'h21, 1'b0);
    do_access(1'b1, 8'h20, 8'h11, 1'b0);
    do_access(1'b1, 8'h20, 8'h77, 1'b1);
    do_access(1'b0, 8'h20, 8'h00, 1'b0);
    do_access(1'b0, 8'h1F, 8'h00, 1'b0);
    do_access(1'b0, 8'h21, 8'h00, 1'b0);

    // Reset during the wait phase aborts the write.
    do_access(1'b1, 8'h20, 8'h11, 1'b0);
    we = 1'b1; addr = 8'h20; wdata = 8'hEE; req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    reset = 1'b0;
    #1;
    check_eq("abort_busy", 32'(busy2), 32'd0);
    check_eq("abort_ack", 32'(ack2), 32'd0);
    check_eq("abort_rdata", 32'(rdata2), 32'd0);
    last_rd[0] = '0;
    last_rd[1] = '0;
    repeat (4) begin
      @(posedge clk); #1;
      check_eq("abort_no_ack", 32'(ack2), 32'd0);
    end
    reset = 1'b1;
    do_access(1'b0, 8'h20, 8'h00, 1'b0);

    // Zero-wait instance with req held high: acks every 3 cycles.
    use0 = 1'b1;
    cur_a = 8'h00; cur_d = 8'h5A;
    we = 1'b1; addr = cur_a; wdata = cur_d; req = 1'b1;
    k = 0; prev = -1;
    for (int cyc = 0; cyc < 40 && k < 6; cyc++) begin
      @(posedge clk); #1;
      if (ack0) begin
        if (prev >= 0) check_eq("b2b_period", 32'(cyc - prev), 32'd3);
        prev = cyc;
        ref_mem[1][cur_a] = cur_d;
        k++;
        cur_a = (k % 2 == 1) ? 8'hFF : 8'h00;
        cur_d = 8'($urandom);
        addr = cur_a; wdata = cur_d;
        if (k == 6) req = 1'b0;
      end
    end
    req = 1'b0;
    check_eq("b2b_count", 32'(k), 32'd6);
    @(posedge clk); #1;
    do_access(1'b0, 8'h00, 8'h00, 1'b0);
    do_access(1'b0, 8'hFF, 8'h00, 1'b0);

    // Randomised traffic over a pre-initialised window on both instances.
    for (int s = 0; s < 2; s++) begin
      use0 = (s == 1);
      for (int i = 0; i < 16; i++) do_access(1'b1, 8'(8'h40 + i), 8'($urandom), 1'b0);
    end
    for (int i = 0; i < 40; i++) begin
      use0 = 1'($urandom_range(0, 1));
      do_access(1'($urandom_range(0, 1)), 8'(8'h40 + $urandom_range(0, 15)),
                8'($urandom), 1'b1);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
